// File: rtl/stopwatch_timer.sv
// stopwatch_timer: six-digit BCD mm:ss.cc stopwatch with lap freeze, clear and wrap/saturate
module stopwatch_timer #(
    parameter bit WRAP_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       run,
    input  logic       clear,
    input  logic       lap,
    output logic [3:0] cs_lo,
    output logic [3:0] cs_hi,
    output logic [3:0] s_lo,
    output logic [3:0] s_hi,
    output logic [3:0] m_lo,
    output logic [3:0] m_hi,
    output logic       lap_active,
    output logic       rollover
);
    typedef enum logic {LIVE, FROZEN} state_t;
    localparam logic [5:0][3:0] MAX = 24'h595999;
    state_t          state_q, state_d;
    logic [5:0][3:0] live_q, live_d, lap_q, lap_d, disp;
    logic            rollover_q, rollover_d, c;
    // live count: BCD cascade with wrap or saturate at 59:59.99, clear wins
    always_comb begin
        live_d     = live_q;
        rollover_d = 1'b0;
        c          = run & tick;
        if (clear) begin
            live_d = '0;
        end else if (c && live_q == MAX) begin
            live_d     = WRAP_EN ? '0 : live_q;
            rollover_d = WRAP_EN;
        end else begin
            for (int i = 0; i < 6; i++) begin
                if (c) begin
                    if (live_q[i] >= ((i == 3 || i == 5) ? 4'd5 : 4'd9)) begin
                        live_d[i] = 4'd0;
                    end else begin
                        live_d[i] = live_q[i] + 4'd1;
                        c         = 1'b0;
                    end
                end
            end
        end
    end
    // lap FSM: first lap snapshots the registered count, second lap returns to live
    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        if (clear) begin
            state_d = LIVE;
            lap_d   = '0;
        end else if (lap) begin
            state_d = (state_q == LIVE) ? FROZEN : LIVE;
            lap_d   = (state_q == LIVE) ? live_q : lap_q;
        end
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LIVE;
            live_q     <= '0;
            lap_q      <= '0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            live_q     <= live_d;
            lap_q      <= lap_d;
            rollover_q <= rollover_d;
        end
    end
    assign disp       = (state_q == FROZEN) ? lap_q : live_q;
    assign cs_lo      = disp[0];
    assign cs_hi      = disp[1];
    assign s_lo       = disp[2];
    assign s_hi       = disp[3];
    assign m_lo       = disp[4];
    assign m_hi       = disp[5];
    assign lap_active = (state_q == FROZEN);
    assign rollover   = rollover_q;
endmodule

// File: tb/tb_stopwatch_timer.sv
// tb_stopwatch_timer: scoreboard bench for wrap and saturate instances against a centisecond model
module tb_stopwatch_timer;
    logic clk = 1'b0, rst = 1'b0, tick = 1'b0, run = 1'b0, clear = 1'b0, lap = 1'b0;
    logic [3:0] w_cs_lo, w_cs_hi, w_s_lo, w_s_hi, w_m_lo, w_m_hi;
    logic [3:0] s_cs_lo, s_cs_hi, s_s_lo, s_s_hi, s_m_lo, s_m_hi;
    logic       w_lap, w_ro, s_lap, s_ro;
    logic [23:0] pre_v;
    logic [51:0] sb[$];
    int vectors = 0, miscompares = 0;
    int c[2], lapv[2], fr[2], ro[2];

    always #5 clk = ~clk;

    stopwatch_timer #(.WRAP_EN(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .lap(lap),
        .cs_lo(w_cs_lo), .cs_hi(w_cs_hi), .s_lo(w_s_lo), .s_hi(w_s_hi), .m_lo(w_m_lo), .m_hi(w_m_hi),
        .lap_active(w_lap), .rollover(w_ro)
    );
    stopwatch_timer #(.WRAP_EN(1'b0)) u_sat (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .clear(clear), .lap(lap),
        .cs_lo(s_cs_lo), .cs_hi(s_cs_hi), .s_lo(s_s_lo), .s_hi(s_s_hi), .m_lo(s_m_lo), .m_hi(s_m_hi),
        .lap_active(s_lap), .rollover(s_ro)
    );

    function automatic logic [23:0] bcd(input int v);
        int m, s, k;
        m = v / 6000;
        s = (v / 100) % 60;
        k = v % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(k / 10), 4'(k % 10)};
    endfunction

    function automatic logic [25:0] expv(input int i);
        return {fr[i][0], ro[i][0], bcd(fr[i] != 0 ? lapv[i] : c[i])};
    endfunction

    task automatic step(input logic r, input logic cl, input logic rn, input logic tk, input logic lp);
        int n;
        rst = r; clear = cl; run = rn; tick = tk; lap = lp;
        for (int i = 0; i < 2; i++) begin
            if (r || cl) begin
                c[i] = 0; lapv[i] = 0; fr[i] = 0; ro[i] = 0;
            end else begin
                n = (rn && tk) ? c[i] + 1 : c[i];
                ro[i] = 0;
                if (n == 360000) begin
                    n = (i == 0) ? 0 : 359999;
                    ro[i] = (i == 0) ? 1 : 0;
                end
                if (lp) begin
                    if (fr[i] == 0) lapv[i] = c[i];
                    fr[i] = (fr[i] == 0) ? 1 : 0;
                end
                c[i] = n;
            end
        end
        sb.push_back({expv(0), expv(1)});
        @(negedge clk);
    endtask

    task automatic preload(input int v);
        pre_v = bcd(v);
        force u_wrap.live_q = pre_v;
        force u_sat.live_q = pre_v;
        c[0] = v; c[1] = v;
        step(0, 0, 0, 0, 0);
        release u_wrap.live_q;
        release u_sat.live_q;
    endtask

    task automatic check(input string name, input logic [25:0] act, input logic [25:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got lap=%b ro=%b %h, expected lap=%b ro=%b %h",
                     name, $time, act[25], act[24], act[23:0], exp[25], exp[24], exp[23:0]);
        end
    endtask

    // monitor: the DUT presents a display every cycle, checked against the queued model output
    initial begin
        logic [51:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("wrap", {w_lap, w_ro, w_m_hi, w_m_lo, w_s_hi, w_s_lo, w_cs_hi, w_cs_lo}, e[51:26]);
                check("sat", {s_lap, s_ro, s_m_hi, s_m_lo, s_s_hi, s_s_lo, s_cs_hi, s_cs_lo}, e[25:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        step(1, 0, 0, 0, 0);
        repeat (100) step(0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0);
        preload(359999);
        step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 1, 0);
        step(0, 1, 0, 0, 0);
        repeat (1234) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1);
        repeat (50) step(0, 0, 1, 1, 0);
        step(0, 0, 1, 0, 1);
        step(0, 1, 0, 0, 0);
        preload(18755);
        step(0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        repeat (7) step(0, 0, 1, 1, 0);
        repeat (20) step(0, 0, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        preload(4510);
        step(0, 0, 1, 0, 1);
        step(0, 0, 1, 1, 0);
        step(1, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0);
        preload(359990);
        repeat (3000) step($urandom_range(199) == 0, $urandom_range(99) == 0,
                           $urandom_range(9) != 0, $urandom_range(1) == 0, $urandom_range(29) == 0);
        repeat (3) @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
